// File: rtl/mem_1rw_byte_mask_req_adapter.sv
// Initiator-side controller for a 1RW byte-masked SRAM wrapper: optional
// zero-fill sweep after reset, credit-gated request issue, 2-entry read FIFO.
module mem_1rw_byte_mask_req_adapter #(
  parameter int width_p       = 64,
  parameter int els_p         = 512,
  parameter int init_p        = 1,
  parameter int addr_width_lp = $clog2(els_p),
  parameter int mask_width_lp = width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     init_done_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [mask_width_lp-1:0] mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                   state_q;
  logic [addr_width_lp-1:0] cnt_q;
  logic                     init_done_q;
  logic                     rd_pend_q, rd_pend_d;
  logic [1:0]               occ_q, occ_d;
  logic [width_p-1:0]       slot0_q, slot0_d;
  logic [width_p-1:0]       slot1_q, slot1_d;

  logic       run;
  logic       deq;
  logic       enq;
  logic       accept;
  logic [2:0] credit;

  assign run    = (state_q == S_RUN);
  assign v_o    = (occ_q != 2'd0);
  assign data_o = slot0_q;
  assign deq    = yumi_i & v_o;
  assign enq    = rd_pend_q;

  // Slots already committed (held + in flight) minus the one leaving this cycle.
  assign credit  = {1'b0, occ_q} + {2'b0, rd_pend_q} - {2'b0, deq};
  assign ready_o = reset_i & run & (credit < 3'd2);
  assign accept  = v_i & ready_o;

  assign mem_v_o      = run ? accept : reset_i;
  assign mem_w_o      = run ? w_i : 1'b1;
  assign mem_addr_o   = run ? addr_i : cnt_q;
  assign mem_data_o   = run ? data_i : '0;
  assign mem_w_mask_o = run ? write_mask_i : '1;
  assign init_done_o  = init_done_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= (init_p != 0) ? S_INIT : S_RUN;
      cnt_q       <= '0;
      init_done_q <= (init_p == 0);
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == addr_width_lp'(els_p - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  always_comb begin
    rd_pend_d = accept & ~w_i;
    occ_d     = occ_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    case ({enq, deq})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = mem_data_i;
        else               slot1_d = mem_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          slot0_d = mem_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = mem_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_pend_q <= 1'b0;
      occ_q     <= 2'd0;
      slot0_q   <= '0;
      slot1_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      occ_q     <= occ_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(enq && !deq && occ_q == 2'd2));
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(yumi_i && !v_o));

endmodule

// File: tb/tb_mem_1rw_byte_mask_req_adapter.sv
// Directed bench for the SRAM request adapter, with a behavioural 1RW
// byte-masked wrapper attached to the mem_* pins.
module tb_mem_1rw_byte_mask_req_adapter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic        w_i;
  logic [8:0]  addr_i;
  logic [63:0] data_i;
  logic [7:0]  write_mask_i;
  logic        v_o;
  logic [63:0] data_o;
  logic        yumi_i;
  logic        init_done_o;
  logic        mem_v_o;
  logic        mem_w_o;
  logic [8:0]  mem_addr_o;
  logic [63:0] mem_data_o;
  logic [7:0]  mem_w_mask_o;
  logic [63:0] mem_data_i;

  logic        auto_yumi;
  logic        yumi_drv;
  int          checks = 0;
  int          errors = 0;

  logic [63:0] sram [512];

  always #5 clk_i = ~clk_i;

  assign yumi_i = auto_yumi ? v_o : yumi_drv;

  mem_1rw_byte_mask_req_adapter dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .write_mask_i(write_mask_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .init_done_o(init_done_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // Wrapper model: read data appears the cycle after the read is issued.
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < 8; b++)
          if (mem_w_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else begin
        mem_data_i <= sram[mem_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 7);
  endfunction

  // Entered just after reset release, before the first sweep edge.
  task automatic run_sweep(input string tag);
    for (int i = 0; i < 512; i++) begin
      #1;
      chk({tag, "_addr"}, {55'd0, mem_addr_o}, 64'(i));
      chk({tag, "_flags"}, {59'd0, mem_v_o, mem_w_o, ready_o, init_done_o, v_o}, 64'b11000);
      chk({tag, "_data_mask"}, mem_data_o | {56'd0, ~mem_w_mask_o}, 64'd0);
      @(negedge clk_i);
    end
    #1;
    chk({tag, "_done"}, {62'd0, init_done_o, ready_o}, 64'b11);
  endtask

  task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
    v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; write_mask_i = m;
    #1 chk("wr_issue", {62'd0, mem_v_o, mem_w_o}, 64'b11);
    @(negedge clk_i);
    v_i = 1'b0;
    #1;
  endtask

  task automatic do_read(input string tag, input logic [8:0] a, input logic [63:0] exp);
    v_i = 1'b1; w_i = 1'b0; addr_i = a;
    #1 chk({tag, "_issue"}, {62'd0, mem_v_o, mem_w_o}, 64'b10);
    @(negedge clk_i);
    v_i = 1'b0;
    #1 chk({tag, "_lat1"}, {63'd0, v_o}, 64'd0);
    @(negedge clk_i);
    #1 chk({tag, "_v"}, {63'd0, v_o}, 64'd1);
    chk({tag, "_data"}, data_o, exp);
    yumi_drv = 1'b1;
    @(negedge clk_i);
    yumi_drv = 1'b0;
    #1 chk({tag, "_empty"}, {63'd0, v_o}, 64'd0);
  endtask

  initial begin
    reset_i = 1'b0; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0;
    write_mask_i = '0; yumi_drv = 1'b0; auto_yumi = 1'b0;

    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_state", {60'd0, ready_o, v_o, mem_v_o, init_done_o}, 64'd0);

    reset_i = 1'b1;
    run_sweep("init");

    do_write(9'd5, 64'h1122334455667788, 8'hFF);
    do_read("rd_full", 9'd5, 64'h1122334455667788);
    do_write(9'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_read("rd_mask", 9'd5, 64'h11223344AAAAAAAA);

    // Backpressure: FIFO fills with two reads, third waits for a pop.
    do_write(9'd1, 64'h0101_0101_0101_0101, 8'hFF);
    do_write(9'd2, 64'h0202_0202_0202_0202, 8'hFF);
    do_write(9'd3, 64'h0303_0303_0303_0303, 8'hFF);
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd1;
    #1 chk("bp_acc1", {63'd0, ready_o}, 64'd1);
    @(negedge clk_i);
    addr_i = 9'd2;
    #1 chk("bp_acc2", {63'd0, ready_o}, 64'd1);
    @(negedge clk_i);
    addr_i = 9'd3;
    #1 chk("bp_stall1", {61'd0, ready_o, mem_v_o, v_o}, 64'b001);
    chk("bp_head1", data_o, 64'h0101_0101_0101_0101);
    @(negedge clk_i);
    #1 chk("bp_full", {62'd0, ready_o, mem_v_o}, 64'b00);
    @(negedge clk_i);
    #1 chk("bp_hold", {62'd0, ready_o, mem_v_o}, 64'b00);
    chk("bp_hold_head", data_o, 64'h0101_0101_0101_0101);
    yumi_drv = 1'b1;
    #1 chk("bp_pop_accept", {61'd0, ready_o, mem_v_o, mem_w_o}, 64'b110);
    @(negedge clk_i);
    yumi_drv = 1'b0; v_i = 1'b0;
    #1 chk("bp_head2", data_o, 64'h0202_0202_0202_0202);
    @(negedge clk_i);
    #1 chk("bp_head2_hold", {63'd0, v_o}, 64'd1);
    yumi_drv = 1'b1;
    @(negedge clk_i);
    yumi_drv = 1'b0;
    #1 chk("bp_head3", data_o, 64'h0303_0303_0303_0303);
    yumi_drv = 1'b1;
    @(negedge clk_i);
    yumi_drv = 1'b0;
    #1 chk("bp_drained", {63'd0, v_o}, 64'd0);

    // Streaming reads with the consumer always taking data.
    for (int i = 0; i < 16; i++) do_write(9'(i), pat(i), 8'hFF);
    auto_yumi = 1'b1;
    for (int i = 0; i < 18; i++) begin
      v_i = (i < 16); w_i = 1'b0; addr_i = 9'(i % 16);
      #1;
      if (i < 16) chk("st_ready", {63'd0, ready_o}, 64'd1);
      if (i >= 2) begin
        chk("st_v", {63'd0, v_o}, 64'd1);
        chk("st_data", data_o, pat(i - 2));
      end
      @(negedge clk_i);
    end
    v_i = 1'b0;
    #1 chk("st_end", {63'd0, v_o}, 64'd0);
    auto_yumi = 1'b0;

    // Reset in the middle of the sweep.
    reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    #1 chk("rst2_addr0", {55'd0, mem_addr_o}, 64'd0);
    repeat (200) @(negedge clk_i);
    #1 chk("rst2_at200", {54'd0, mem_v_o, mem_addr_o}, {54'd0, 1'b1, 9'd200});
    reset_i = 1'b0;
    #1 chk("rst2_drop", {61'd0, mem_v_o, ready_o, init_done_o}, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    run_sweep("reinit");
    do_read("rd_zeroed", 9'd5, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_1rw_byte_mask_req_adapter.md
Name: mem_1rw_byte_mask_req_adapter

Overview:
- Initiator-side controller for a 1RW byte-masked SRAM wrapper (default 512 x 64).
- Accepts ready/valid read and write requests and drives the wrapper's v/w/addr/data/mask pins.
- Captures each read result on the cycle after issue and holds it in a 2-entry response FIFO, so the consumer can apply backpressure without losing data.
- Optional post-reset zero-initialisation sweep.

Parameters:
- width_p, 64, data width in bits; must be a multiple of 8.
- els_p, 512, number of words.
- init_p, 1, 1 = zero-fill every word after reset; 0 = skip the sweep.
- addr_width_lp, $clog2(els_p), address width (derived).
- mask_width_lp, width_p>>3, byte-mask width (derived).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- v_i  in  1  request valid.
- ready_o  out  1  request ready; a request transfers when v_i & ready_o.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_lp  request address.
- data_i  in  width_p  write data.
- write_mask_i  in  mask_width_lp  per-byte write enable.
- v_o  out  1  read data valid.
- data_o  out  width_p  read data (FIFO head).
- yumi_i  in  1  consumer takes data_o this cycle; legal only while v_o=1.
- init_done_o  out  1  high once the init sweep is complete (or immediately if init_p=0).
- mem_v_o  out  1  to wrapper v_i.
- mem_w_o  out  1  to wrapper w_i.
- mem_addr_o  out  addr_width_lp  to wrapper addr_i.
- mem_data_o  out  width_p  to wrapper data_i.
- mem_w_mask_o  out  mask_width_lp  to wrapper write_mask_i.
- mem_data_i  in  width_p  from wrapper data_o; valid the cycle after a read is issued.

Behaviour:
- Clock and reset: one clock (clk_i); reset (reset_i) is asynchronous and active-low.
- Reset state:
  - state = INIT if init_p=1, else RUN.
  - Init counter = 0, FIFO empty, rd_pend = 0.
  - ready_o = 0, v_o = 0, mem_v_o = 0, init_done_o = init_p ? 0 : 1.
- INIT state:
  - Every cycle: mem_v_o=1, mem_w_o=1, mem_addr_o=cnt, mem_data_o=0, mem_w_mask_o=all ones; cnt increments.
  - After the write to els_p-1 the FSM moves to RUN; init_done_o rises in the first RUN cycle and stays high until reset.
  - ready_o=0 throughout; v_i is ignored.
  - The sweep takes exactly els_p cycles.
- RUN state, request side:
  - ready_o = (occ + rd_pend - (yumi_i & v_o)) < 2, where occ is FIFO occupancy.
  - ready_o must not depend on v_i or w_i. Reads and writes are gated identically.
- Issue:
  - mem_v_o = v_i & ready_o, combinational.
  - mem_w_o, mem_addr_o, mem_data_o and mem_w_mask_o pass through combinationally from w_i, addr_i, data_i and write_mask_i.
  - When mem_v_o=0, the mem_* data outputs are don't-care.
- Reads:
  - An accepted read sets rd_pend=1 for the next cycle.
  - In that cycle mem_data_i is enqueued and rd_pend clears, unless a new read is accepted in the same cycle, in which case rd_pend stays 1.
  - Read latency: accept at cycle N → v_o=1 with data at N+2 at the earliest.
- Writes:
  - No response is generated.
  - Bytes with write_mask_i=0 are left unchanged by the wrapper.
  - A read to the same address accepted in the following cycle returns the new data.
- Response FIFO:
  - 2 entries, in-order, data_o = head.
  - Simultaneous enqueue and dequeue leaves occupancy unchanged; both operations occur.
  - The credit rule guarantees no enqueue when full (checked by assertion).
  - yumi_i while v_o=0 is illegal (assertion).
- Throughput: back-to-back reads with yumi_i held high sustain one read per cycle.
- Reset mid-operation: the in-flight read and FIFO contents are discarded. Reset mid-INIT restarts the sweep at address 0.

Test Plan:
- init_p=1, release reset → exactly 512 consecutive mem writes, addr 0..511, data 0, mask 0xFF; init_done_o rises at cycle 512; ready_o=0 before that.
- Write addr 5 data 0x1122334455667788 mask 0xFF, then read addr 5 → v_o two cycles after read acceptance, data_o=0x1122334455667788.
- Write addr 5 data 0xAAAAAAAAAAAAAAAA mask 0x0F, then read addr 5 → data_o=0x11223344AAAAAAAA.
- yumi_i held 0, v_i=1 reads to addr 1,2,3 → only 2 accepted; ready_o stays 0 with FIFO full. Pulse yumi_i once → addr-1 data popped and the addr-3 read accepted the same cycle.
- Read stream addr 0..15 with yumi_i=1 → one acceptance per cycle, 16 in-order responses, no gaps after the first.
- Assert reset at init address 200 → mem_v_o drops immediately. On release the sweep restarts at 0; init_done_o is 0 until 512 cycles later.
